// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester external memory arbiter.
// The CPU path is requester 0 and the debug/program loader is requester 1.
package crp_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arbState_t;

  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  localparam int         TIMEOUT_DEF   = 16;
  localparam logic [7:0] ERR_RDATA_DEF = 8'hFF;

  // Watchdog counter width; kept at least one bit so a disabled watchdog still elaborates.
  function automatic int wdogWidth(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int WDOG_W_DEF = wdogWidth(TIMEOUT_DEF);

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and external-memory-side signals of the arbiter.
// The arbiter uses the slave view; the environment driving it uses the master view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
) ();

  logic [1:0]              req;
  logic [1:0]              we;
  logic [2*ADDR_WIDTH-1:0] addr;
  logic [2*DATA_WIDTH-1:0] wdata;
  logic [1:0]              gnt;
  logic [1:0]              done;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rdata;

  logic                    ext_valid;
  logic                    ext_we;
  logic [ADDR_WIDTH-1:0]   ext_addr;
  logic [DATA_WIDTH-1:0]   ext_wdata;
  logic                    ext_ready;
  logic [DATA_WIDTH-1:0]   ext_rdata;

  modport slave (
    input  req, we, addr, wdata, ext_ready, ext_rdata,
    output gnt, done, err, rdata, ext_valid, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output req, we, addr, wdata, ext_ready, ext_rdata,
    input  gnt, done, err, rdata, ext_valid, ext_we, ext_addr, ext_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter_rr2.sv
// Two-input round-robin picker. On a tie the pointer names the winner, and the
// pointer moves away from whoever was just served when update is strobed.
module mem_arb_rr2
  import crp_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       servedIdx,
  output logic       pickValid,
  output logic       pickIdx
);

  logic ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~servedIdx;
    end
  end

  always_comb begin
    pickValid = |req;
    if (req[REQ_CPU] && req[REQ_DBG]) begin
      pickIdx = ptr;
    end else begin
      pickIdx = req[REQ_DBG];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one byte-wide external memory port between the CPU and the debug loader:
// round-robin grant, one valid/ready transaction, done pulse, watchdog abort.
module mem_bus_arbiter
  import crp_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 15,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    TIMEOUT    = TIMEOUT_DEF,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA  = ERR_RDATA_DEF
) (
  input logic              clk,
  input logic              reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int                WDOG_W     = wdogWidth(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arbState_t             state;
  logic [1:0]            gntReg;
  logic [1:0]            doneReg;
  logic                  errReg;
  logic [DATA_WIDTH-1:0] rdataReg;
  logic                  extValid;
  logic                  extWe;
  logic [ADDR_WIDTH-1:0] extAddr;
  logic [DATA_WIDTH-1:0] extWdata;
  logic                  curIdx;
  logic [WDOG_W-1:0]     wdogCnt;

  logic                  pickValid;
  logic                  pickIdx;
  logic                  pickWe;
  logic [ADDR_WIDTH-1:0] pickAddr;
  logic [DATA_WIDTH-1:0] pickWdata;
  logic                  wdogHit;
  logic                  finishing;

  mem_arb_rr2 rr (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req),
    .update    (finishing),
    .servedIdx (curIdx),
    .pickValid (pickValid),
    .pickIdx   (pickIdx)
  );

  always_comb begin
    pickWe    = bus.we[pickIdx];
    pickAddr  = pickIdx ? bus.addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.addr[ADDR_WIDTH-1:0];
    pickWdata = pickIdx ? bus.wdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.wdata[DATA_WIDTH-1:0];
  end

  // A ready arriving in the watchdog's last cycle wins over the abort.
  assign wdogHit   = (TIMEOUT > 0) && (wdogCnt == WDOG_LIMIT);
  assign finishing = (state == ST_ACCESS) && (bus.ext_ready || wdogHit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      gntReg   <= '0;
      doneReg  <= '0;
      errReg   <= 1'b0;
      rdataReg <= '0;
      extValid <= 1'b0;
      extWe    <= 1'b0;
      extAddr  <= '0;
      extWdata <= '0;
      curIdx   <= 1'b0;
      wdogCnt  <= '0;
    end else begin
      gntReg  <= '0;
      doneReg <= '0;
      errReg  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pickValid) begin
            state           <= ST_ACCESS;
            curIdx          <= pickIdx;
            gntReg[pickIdx] <= 1'b1;
            extValid        <= 1'b1;
            extWe           <= pickWe;
            extAddr         <= pickAddr;
            extWdata        <= pickWdata;
            wdogCnt         <= '0;
          end
        end
        ST_ACCESS: begin
          if (bus.ext_ready) begin
            state           <= ST_DONE;
            extValid        <= 1'b0;
            doneReg[curIdx] <= 1'b1;
            if (!extWe) begin
              rdataReg <= bus.ext_rdata;
            end
          end else if (wdogHit) begin
            state           <= ST_DONE;
            extValid        <= 1'b0;
            doneReg[curIdx] <= 1'b1;
            errReg          <= 1'b1;
            if (!extWe) begin
              rdataReg <= ERR_RDATA;
            end
          end else begin
            wdogCnt <= wdogCnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gntReg;
  assign bus.done      = doneReg;
  assign bus.err       = errReg;
  assign bus.rdata     = rdataReg;
  assign bus.ext_valid = extValid;
  assign bus.ext_we    = extWe;
  assign bus.ext_addr  = extAddr;
  assign bus.ext_wdata = extWdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
  import crp_mem_pkg::*;

  localparam int         AW   = 15;
  localparam int         DW   = 8;
  localparam int         TMO  = 16;
  localparam logic [7:0] ERRD = 8'hFF;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  // Model state: who wins the next tie, and the last rdata the requesters saw.
  int         modelPtr;
  logic [7:0] modelRdata;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_bus_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO),
    .ERR_RDATA  (ERRD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] reqs, input logic [1:0] wes,
                               input logic [14:0] a0, input logic [14:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
    bus.req   = reqs;
    bus.we    = wes;
    bus.addr  = {a1, a0};
    bus.wdata = {d1, d0};
  endtask

  task automatic doReset();
    reset         = 1'b1;
    bus.req       = 2'b00;
    bus.ext_ready = 1'b0;
    tick();
    reset      = 1'b0;
    modelPtr   = 0;
    modelRdata = 8'h00;
  endtask

  // One complete access: grant, readyDelay stall cycles (or timeout), done, back to idle.
  task automatic runAccess(input string tag, input logic [1:0] reqs, input logic [1:0] wes,
                           input logic [14:0] a0, input logic [14:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input int readyDelay, input logic [7:0] rd, input bit holdReq);
    int         w;
    int         last;
    bit         timedOut;
    logic       expWe;
    logic [14:0] expAddr;
    logic [7:0] expWdata;
    if (reqs == 2'b11) w = modelPtr;
    else w = reqs[1] ? 1 : 0;
    expWe    = wes[w];
    expAddr  = (w == 1) ? a1 : a0;
    expWdata = (w == 1) ? d1 : d0;
    timedOut = (TMO > 0) && (readyDelay >= TMO);
    last     = timedOut ? TMO - 1 : readyDelay;

    applyStimulus(reqs, wes, a0, a1, d0, d1);
    bus.ext_ready = 1'b0;
    tick();
    checkOutput({tag, "/gnt"}, 32'(bus.gnt), 32'(1 << w));
    checkOutput({tag, "/valid"}, 32'(bus.ext_valid), 32'd1);
    checkOutput({tag, "/addr"}, 32'(bus.ext_addr), 32'(expAddr));
    checkOutput({tag, "/we"}, 32'(bus.ext_we), 32'(expWe));
    checkOutput({tag, "/wdata"}, 32'(bus.ext_wdata), 32'(expWdata));
    if (!holdReq) bus.req = 2'b00;

    for (int k = 0; k <= last; k++) begin
      bus.addr      = 30'($urandom);
      bus.wdata     = 16'($urandom);
      bus.we        = 2'($urandom);
      bus.ext_ready = (k == last) && !timedOut;
      bus.ext_rdata = bus.ext_ready ? rd : 8'($urandom);
      tick();
      if (k < last) begin
        checkOutput({tag, "/stallValid"}, 32'(bus.ext_valid), 32'd1);
        checkOutput({tag, "/stallAddr"}, 32'(bus.ext_addr), 32'(expAddr));
        checkOutput({tag, "/stallWe"}, 32'(bus.ext_we), 32'(expWe));
        checkOutput({tag, "/stallWdata"}, 32'(bus.ext_wdata), 32'(expWdata));
        checkOutput({tag, "/stallDone"}, 32'(bus.done), 32'd0);
      end
    end

    if (!expWe) modelRdata = timedOut ? ERRD : rd;
    modelPtr = 1 - w;
    checkOutput({tag, "/done"}, 32'(bus.done), 32'(1 << w));
    checkOutput({tag, "/err"}, 32'(bus.err), 32'(timedOut));
    checkOutput({tag, "/rdata"}, 32'(bus.rdata), 32'(modelRdata));
    checkOutput({tag, "/validOff"}, 32'(bus.ext_valid), 32'd0);

    bus.ext_ready = 1'($urandom);
    tick();
    bus.ext_ready = 1'b0;
    checkOutput({tag, "/doneLow"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "/errLow"}, 32'(bus.err), 32'd0);
    checkOutput({tag, "/gntLow"}, 32'(bus.gnt), 32'd0);
    checkOutput({tag, "/rdataHeld"}, 32'(bus.rdata), 32'(modelRdata));
  endtask

  initial begin
    reset         = 1'b1;
    bus.ext_ready = 1'b0;
    bus.ext_rdata = 8'h00;
    applyStimulus(2'b00, 2'b00, 15'h0, 15'h0, 8'h0, 8'h0);
    tick();
    tick();
    doReset();
    checkOutput("rst/gnt", 32'(bus.gnt), 32'd0);
    checkOutput("rst/done", 32'(bus.done), 32'd0);
    checkOutput("rst/err", 32'(bus.err), 32'd0);
    checkOutput("rst/rdata", 32'(bus.rdata), 32'd0);
    checkOutput("rst/valid", 32'(bus.ext_valid), 32'd0);

    runAccess("read1", 2'b01, 2'b00, 15'h1234, 15'h0042, 8'h11, 8'h22, 0, 8'hA5, 1'b0);

    // Held tie: grants alternate starting with the CPU, and reset restores that order.
    doReset();
    for (int i = 0; i < 4; i++) begin
      runAccess("tie", 2'b11, 2'b00, 15'($urandom), 15'($urandom), 8'h0, 8'h0, 0,
                8'($urandom), 1'b1);
    end
    bus.req = 2'b00;
    doReset();
    runAccess("tieAfterRst", 2'b11, 2'b00, 15'h0100, 15'h0200, 8'h0, 8'h0, 0, 8'h5C, 1'b0);

    runAccess("stallWrite", 2'b10, 2'b10, 15'h0ABC, 15'h7FFF, 8'h99, 8'h3C, 5, 8'h77, 1'b0);

    runAccess("timeout", 2'b01, 2'b00, 15'h0321, 15'h0, 8'h0, 8'h0, 40, 8'h12, 1'b0);
    runAccess("readyAtLimit", 2'b01, 2'b00, 15'h0322, 15'h0, 8'h0, 8'h0, TMO - 1, 8'h5A, 1'b0);
    runAccess("timeoutWrite", 2'b10, 2'b10, 15'h0, 15'h0323, 8'h0, 8'hE1, TMO + 3, 8'h00, 1'b0);

    // Reset while a read is stalled: the access must vanish without a done pulse.
    applyStimulus(2'b01, 2'b00, 15'h2222, 15'h0, 8'h0, 8'h0);
    bus.ext_ready = 1'b0;
    tick();
    checkOutput("midRst/gnt", 32'(bus.gnt), 32'd1);
    bus.req = 2'b00;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    modelPtr   = 0;
    modelRdata = 8'h00;
    checkOutput("midRst/valid", 32'(bus.ext_valid), 32'd0);
    checkOutput("midRst/gnt0", 32'(bus.gnt), 32'd0);
    checkOutput("midRst/done0", 32'(bus.done), 32'd0);
    checkOutput("midRst/err0", 32'(bus.err), 32'd0);
    checkOutput("midRst/rdata0", 32'(bus.rdata), 32'd0);
    for (int i = 0; i < 20; i++) begin
      bus.ext_ready = 1'b1;
      bus.ext_rdata = 8'($urandom);
      tick();
      checkOutput("midRst/noDone", 32'(bus.done), 32'd0);
      checkOutput("idleReady/noValid", 32'(bus.ext_valid), 32'd0);
      checkOutput("idleReady/noGnt", 32'(bus.gnt), 32'd0);
    end
    bus.ext_ready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      logic [1:0] r;
      int         dly;
      r   = 2'($urandom_range(1, 3));
      dly = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TMO - 2, TMO + 4))
                                        : int'($urandom_range(0, 6));
      runAccess("rand", r, 2'($urandom), 15'($urandom), 15'($urandom), 8'($urandom),
                8'($urandom), dly, 8'($urandom), 1'($urandom));
    end
    bus.req = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
